// File: rtl/branch_pred_queue_if.sv
// -----------------------------------------------------------------------------
// branch_pred_queue_if
//
// Bundles the fetch-side push channel, the execute-side resolve channel, the
// queue status flags and the BHT update / redirect outputs of
// branch_pred_queue. Clock and reset are not part of the bundle.
//
// Modports:
//   master : the fetch/execute side. It drives stall, push and resolve and
//            observes status, BHT update and redirect.
//   slave  : the queue itself.
//
// Parameters:
//   PTR_W       log2 of the queue depth (count_o is PTR_W+1 bits wide)
//   INDEX_WIDTH BHT set index width
//   ADDR_WIDTH  PC / target width
// -----------------------------------------------------------------------------
interface branch_pred_queue_if #(
  parameter int PTR_W       = 2,
  parameter int INDEX_WIDTH = 5,
  parameter int ADDR_WIDTH  = 64
);

  // Front-end stall
  logic                   stall_fetch_i;

  // Push channel (fetch-stage predictor)
  logic                   push_i;
  logic [INDEX_WIDTH-1:0] push_index_i;
  logic                   push_pred_taken_i;
  logic [ADDR_WIDTH-1:0]  push_pred_target_i;

  // Queue status
  logic                   full_o;
  logic                   empty_o;
  logic [PTR_W:0]         count_o;
  logic                   overflow_o;

  // Resolve channel (execute stage)
  logic                   resolve_i;
  logic                   resolve_ready_o;
  logic                   resolve_taken_i;
  logic [ADDR_WIDTH-1:0]  resolve_target_i;
  logic [ADDR_WIDTH-1:0]  resolve_next_pc_i;

  // BHT update and front-end redirect
  logic                   bht_update_o;
  logic                   branch_taken_o;
  logic [INDEX_WIDTH-1:0] set_index_exec_o;
  logic                   mispredict_o;
  logic [ADDR_WIDTH-1:0]  redirect_pc_o;

  modport master (
    output stall_fetch_i,
    output push_i, push_index_i, push_pred_taken_i, push_pred_target_i,
    input  full_o, empty_o, count_o, overflow_o,
    output resolve_i, resolve_taken_i, resolve_target_i, resolve_next_pc_i,
    input  resolve_ready_o,
    input  bht_update_o, branch_taken_o, set_index_exec_o,
    input  mispredict_o, redirect_pc_o
  );

  modport slave (
    input  stall_fetch_i,
    input  push_i, push_index_i, push_pred_taken_i, push_pred_target_i,
    output full_o, empty_o, count_o, overflow_o,
    input  resolve_i, resolve_taken_i, resolve_target_i, resolve_next_pc_i,
    output resolve_ready_o,
    output bht_update_o, branch_taken_o, set_index_exec_o,
    output mispredict_o, redirect_pc_o
  );

endinterface : branch_pred_queue_if

// File: rtl/branch_pred_queue.sv
// -----------------------------------------------------------------------------
// branch_pred_queue
//
// In-order queue of predicted branches sitting between the fetch-stage
// predictor and execute. Each push records the BHT set index, the predicted
// direction and the predicted target. When execute resolves the oldest branch
// the actual outcome is compared with the recorded prediction; the result
// drives the BHT update port one cycle later and, on a mispredict, a
// single-cycle redirect/flush pulse that also empties the queue.
//
// Ports:
//   clk_i     clock, rising edge
//   arstn_i   asynchronous active-low reset
//   bus       branch_pred_queue_if.slave: stall, push channel, resolve
//             channel, status flags, BHT update and redirect outputs
//   stat_branches_o / stat_mispred_o (only with BPQ_STATS_EN)
//             32-bit saturating counters of accepted and mispredicted resolves
//
// Configuration:
//   BPQ_STATS_EN  when defined, adds the two statistics ports and counters.
//                 Core queue behaviour is identical with or without it.
//
// Parameters:
//   DEPTH       in-flight entries, power of two, >= 2
//   PTR_W       log2(DEPTH)
//   INDEX_WIDTH BHT set index width
//   ADDR_WIDTH  PC / target width
// -----------------------------------------------------------------------------
module branch_pred_queue #(
  parameter int DEPTH       = 4,
  parameter int PTR_W       = 2,
  parameter int INDEX_WIDTH = 5,
  parameter int ADDR_WIDTH  = 64
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  branch_pred_queue_if.slave  bus
`ifdef BPQ_STATS_EN
  ,
  output logic [31:0]         stat_branches_o,
  output logic [31:0]         stat_mispred_o
`endif
);

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] index;
    logic                   pred_taken;
    logic [ADDR_WIDTH-1:0]  pred_target;
  } entry_t;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t                 mem [DEPTH];
  logic [PTR_W-1:0]       head_q;
  logic [PTR_W-1:0]       tail_q;
  logic [PTR_W:0]         count_q;
  logic                   overflow_q;

  logic                   bht_update_q;
  logic                   branch_taken_q;
  logic [INDEX_WIDTH-1:0] set_index_q;
  logic                   mispredict_q;
  logic [ADDR_WIDTH-1:0]  redirect_pc_q;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic   full;
  logic   empty;
  logic   resolve_ready;
  logic   push_acc;
  logic   push_drop;
  logic   res_acc;
  logic   mispred;
  logic   flush;
  entry_t head_entry;

  // count is the only full/empty arbiter; head == tail is ambiguous.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // A BHT update held through a stall blocks the next resolve so the held
  // taken/index values cannot be overwritten before the BHT has seen them.
  assign resolve_ready = ~(bht_update_q & bus.stall_fetch_i);

  // full is taken from the current count, so a resolve in the same cycle
  // does not make room for a push.
  assign push_acc  = bus.push_i & ~full & ~bus.stall_fetch_i;
  assign push_drop = bus.push_i & full;
  assign res_acc   = bus.resolve_i & resolve_ready & ~empty;

  assign head_entry = mem[head_q];

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    mispred = 1'b0;
    if (head_entry.pred_taken != bus.resolve_taken_i) begin
      mispred = 1'b1;
    end else if (head_entry.pred_taken &&
                 (head_entry.pred_target != bus.resolve_target_i)) begin
      // Direction right but taken to the wrong place.
      mispred = 1'b1;
    end
  end

  assign flush = res_acc & mispred;

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  // NOTE: the entry array has no reset; count decides which slots are live,
  // so stale contents are never observed and the array maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      mem[tail_q] <= '{index:       bus.push_index_i,
                       pred_taken:  bus.push_pred_taken_i,
                       pred_target: bus.push_pred_target_i};
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      // Everything younger than the mispredicted branch is on the wrong path,
      // including a push arriving in the same cycle.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Pointers wrap naturally at DEPTH because DEPTH == 2**PTR_W.
      if (push_acc) tail_q <= tail_q + 1'b1;
      if (res_acc)  head_q <= head_q + 1'b1;
      unique case ({push_acc, res_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky until reset; a flush does not clear it.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      overflow_q <= 1'b0;
    end else if (push_drop) begin
      overflow_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // BHT update and redirect outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      bht_update_q   <= 1'b0;
      branch_taken_q <= 1'b0;
      set_index_q    <= '0;
      mispredict_q   <= 1'b0;
      redirect_pc_q  <= '0;
    end else begin
      // The strobe is held while the front end is stalled because the BHT
      // ignores updates then; it drops on the first unstalled cycle.
      if (res_acc) begin
        bht_update_q   <= 1'b1;
        branch_taken_q <= bus.resolve_taken_i;
        set_index_q    <= head_entry.index;
      end else if (!bus.stall_fetch_i) begin
        bht_update_q   <= 1'b0;
      end

      // The redirect is a one-shot flush request and is never held.
      mispredict_q <= flush;
      if (flush) begin
        redirect_pc_q <= bus.resolve_next_pc_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef BPQ_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispred_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      if (res_acc && (stat_branches_q != '1)) begin
        stat_branches_q <= stat_branches_q + 32'd1;
      end
      if (flush && (stat_mispred_q != '1)) begin
        stat_mispred_q <= stat_mispred_q + 32'd1;
      end
    end
  end

  assign stat_branches_o = stat_branches_q;
  assign stat_mispred_o  = stat_mispred_q;
`endif

  // ---------------------------------------------------------------------------
  // Port drive
  // ---------------------------------------------------------------------------
  assign bus.full_o           = full;
  assign bus.empty_o          = empty;
  assign bus.count_o          = count_q;
  assign bus.overflow_o       = overflow_q;
  assign bus.resolve_ready_o  = resolve_ready;
  assign bus.bht_update_o     = bht_update_q;
  assign bus.branch_taken_o   = branch_taken_q;
  assign bus.set_index_exec_o = set_index_q;
  assign bus.mispredict_o     = mispredict_q;
  assign bus.redirect_pc_o    = redirect_pc_q;

endmodule : branch_pred_queue

// File: tb/tb_branch_pred_queue.sv
// -----------------------------------------------------------------------------
// tb_branch_pred_queue
//
// Drives branch_pred_queue through directed scenarios followed by randomized
// traffic. A queue-of-entries reference model predicts acceptance, occupancy
// and each BHT update; expected updates go to a scoreboard that a separate
// monitor drains whenever the DUT presents a fresh update.
// -----------------------------------------------------------------------------
module tb_branch_pred_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int IW    = 5;
  localparam int AW    = 64;

  logic clk   = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  branch_pred_queue_if #(.PTR_W(PTR_W), .INDEX_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

`ifdef BPQ_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
`endif

  branch_pred_queue #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .INDEX_WIDTH(IW), .ADDR_WIDTH(AW)
  ) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus)
`ifdef BPQ_STATS_EN
    ,
    .stat_branches_o (stat_branches),
    .stat_mispred_o  (stat_mispred)
`endif
  );

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [IW-1:0] idx;
    logic          pt;
    logic [AW-1:0] tgt;
  } ent_t;

  typedef struct {
    logic          taken;
    logic [IW-1:0] idx;
    logic          mis;
    logic [AW-1:0] redirect;
    int            due;
  } upd_t;

  ent_t          mq[$];
  upd_t          exp_q[$];
  bit            m_bht;
  bit            m_ovf;
  logic [AW-1:0] m_redirect;
  int unsigned   m_br;
  int unsigned   m_mis;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_bht      = 1'b0;
    m_ovf      = 1'b0;
    m_redirect = '0;
    m_br       = 0;
    m_mis      = 0;
  endtask

  // One clock of stimulus. The model decides what the queue must do from the
  // inputs and its own state, then status is checked #1 after the edge.
  task automatic step(input bit p, input logic [IW-1:0] idx, input bit pt,
                      input logic [AW-1:0] tgt, input bit r, input bit rt,
                      input logic [AW-1:0] rtgt, input logic [AW-1:0] npc,
                      input bit st);
    ent_t h;
    bit   full, ready, p_ok, r_ok, mis;
    bus.push_i             = p;
    bus.push_index_i       = idx;
    bus.push_pred_taken_i  = pt;
    bus.push_pred_target_i = tgt;
    bus.resolve_i          = r;
    bus.resolve_taken_i    = rt;
    bus.resolve_target_i   = rtgt;
    bus.resolve_next_pc_i  = npc;
    bus.stall_fetch_i      = st;

    ready = !(m_bht && st);
    full  = (mq.size() == DEPTH);
    p_ok  = p && !full && !st;
    r_ok  = r && ready && (mq.size() != 0);
    mis   = 1'b0;
    if (p && full) m_ovf = 1'b1;
    if (r_ok) begin
      h   = mq.pop_front();
      mis = (h.pt != rt) || (h.pt && rt && (h.tgt != rtgt));
      if (mis) m_redirect = npc;
      exp_q.push_back('{taken: rt, idx: h.idx, mis: mis, redirect: m_redirect,
                        due: edge_cnt + 1});
      m_br++;
      if (mis) m_mis++;
    end
    if (r_ok && mis) mq.delete();
    else if (p_ok)   mq.push_back('{idx: idx, pt: pt, tgt: tgt});
    m_bht = r_ok || (m_bht && st);

    @(posedge clk);
    #1;
    check("count_o",         64'(bus.count_o),         64'(mq.size()));
    check("empty_o",         64'(bus.empty_o),         64'(mq.size() == 0));
    check("full_o",          64'(bus.full_o),          64'(mq.size() == DEPTH));
    check("overflow_o",      64'(bus.overflow_o),      64'(m_ovf));
    check("resolve_ready_o", 64'(bus.resolve_ready_o), 64'(!(m_bht && st)));
`ifdef BPQ_STATS_EN
    check("stat_branches_o", 64'(stat_branches), 64'(m_br));
    check("stat_mispred_o",  64'(stat_mispred),  64'(m_mis));
`endif
  endtask

  task automatic push_one(input logic [IW-1:0] idx, input bit pt, input logic [AW-1:0] tgt);
    step(1'b1, idx, pt, tgt, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic resolve_one(input bit rt, input logic [AW-1:0] rtgt,
                             input logic [AW-1:0] npc, input bit st);
    step(1'b0, '0, 1'b0, '0, 1'b1, rt, rtgt, npc, st);
  endtask

  task automatic idle(input bit st);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, st);
  endtask

  task automatic drive_idle_inputs();
    bus.push_i             = 1'b0;
    bus.push_index_i       = '0;
    bus.push_pred_taken_i  = 1'b0;
    bus.push_pred_target_i = '0;
    bus.resolve_i          = 1'b0;
    bus.resolve_taken_i    = 1'b0;
    bus.resolve_target_i   = '0;
    bus.resolve_next_pc_i  = '0;
    bus.stall_fetch_i      = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count_o"},          64'(bus.count_o),          64'd0);
    check({tag, "_empty_o"},          64'(bus.empty_o),          64'd1);
    check({tag, "_full_o"},           64'(bus.full_o),           64'd0);
    check({tag, "_overflow_o"},       64'(bus.overflow_o),       64'd0);
    check({tag, "_resolve_ready_o"},  64'(bus.resolve_ready_o),  64'd1);
    check({tag, "_bht_update_o"},     64'(bus.bht_update_o),     64'd0);
    check({tag, "_branch_taken_o"},   64'(bus.branch_taken_o),   64'd0);
    check({tag, "_set_index_exec_o"}, 64'(bus.set_index_exec_o), 64'd0);
    check({tag, "_mispredict_o"},     64'(bus.mispredict_o),     64'd0);
    check({tag, "_redirect_pc_o"},    64'(bus.redirect_pc_o),    64'd0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    drive_idle_inputs();
    arstn = 1'b0;
    #1;
    check_reset_state("async_rst");
    model_clear();
    @(posedge clk);
    #1;
    arstn = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: a fresh update is a strobe that is not merely the hold of the
  // previous cycle's strobe under stall.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    bit            prev_bht, prev_st;
    logic          taken_l;
    logic [IW-1:0] idx_l;
    logic [AW-1:0] rd_l;
    upd_t          e;
    prev_bht = 1'b0; prev_st = 1'b0; taken_l = 1'b0; idx_l = '0; rd_l = '0;
    forever begin
      @(negedge clk);
      if (!arstn) begin
        prev_bht = 1'b0; prev_st = 1'b0; taken_l = 1'b0; idx_l = '0; rd_l = '0;
        continue;
      end
      if (bus.bht_update_o && !(prev_bht && prev_st)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_update", 64'(bus.bht_update_o), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("update_cycle",     64'(edge_cnt),             64'(e.due));
          check("branch_taken_o",   64'(bus.branch_taken_o),   64'(e.taken));
          check("set_index_exec_o", 64'(bus.set_index_exec_o), 64'(e.idx));
          check("mispredict_o",     64'(bus.mispredict_o),     64'(e.mis));
          check("redirect_pc_o",    64'(bus.redirect_pc_o),    64'(e.redirect));
          taken_l = e.taken; idx_l = e.idx; rd_l = e.redirect;
        end
      end else begin
        if (prev_bht && prev_st) check("bht_update_hold", 64'(bus.bht_update_o), 64'd1);
        check("mispredict_pulse",      64'(bus.mispredict_o),     64'd0);
        check("branch_taken_stable",   64'(bus.branch_taken_o),   64'(taken_l));
        check("set_index_stable",      64'(bus.set_index_exec_o), 64'(idx_l));
        check("redirect_pc_stable",    64'(bus.redirect_pc_o),    64'(rd_l));
        if (exp_q.size() != 0 && exp_q[0].due <= edge_cnt) begin
          check("missing_update", 64'(bus.bht_update_o), 64'd1);
          void'(exp_q.pop_front());
        end
      end
      prev_bht = bus.bht_update_o;
      prev_st  = bus.stall_fetch_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    bit            p, pt, r, rt, st;
    logic [IW-1:0] idx;
    logic [AW-1:0] tgt, rtgt, npc;

    drive_idle_inputs();
    model_clear();
    #1;
    check_reset_state("por");
    @(posedge clk);
    #1;
    arstn = 1'b1;

    // Correctly predicted taken branch.
    push_one(5'd3, 1'b1, 64'h100);
    resolve_one(1'b1, 64'h100, 64'h100, 1'b0);
    idle(1'b0);

    // Predicted not-taken, actually taken: redirect to 0x2000.
    push_one(5'd7, 1'b0, 64'h0);
    resolve_one(1'b1, 64'h2000, 64'h2000, 1'b0);
    idle(1'b0);

    // Mispredict of the oldest of four flushes the rest; a later resolve
    // against the empty queue is ignored.
    for (int i = 1; i <= 4; i++) push_one(IW'(i), 1'b0, 64'h0);
    resolve_one(1'b1, 64'h3000, 64'h3000, 1'b0);
    resolve_one(1'b0, 64'h0, 64'h3004, 1'b0);
    idle(1'b0);

    // Fill, overflow, drain in order across the wrap.
    for (int i = 1; i <= 4; i++) push_one(IW'(i), 1'b0, 64'h0);
    push_one(5'd9, 1'b0, 64'h0);
    for (int i = 0; i < 4; i++) resolve_one(1'b0, 64'h0, 64'h10, 1'b0);
    idle(1'b0);

    // Update held through a three-cycle stall; second resolve waits.
    push_one(5'd5, 1'b1, 64'h500);
    push_one(5'd6, 1'b0, 64'h0);
    resolve_one(1'b1, 64'h500, 64'h500, 1'b1);
    resolve_one(1'b0, 64'h0, 64'h20, 1'b1);
    resolve_one(1'b0, 64'h0, 64'h20, 1'b1);
    idle(1'b0);
    resolve_one(1'b0, 64'h0, 64'h20, 1'b0);
    idle(1'b0);

    // Push and correct resolve together at count 2, then reset mid-stream.
    push_one(5'd10, 1'b1, 64'hA00);
    push_one(5'd11, 1'b0, 64'h0);
    step(1'b1, 5'd12, 1'b1, 64'hC00, 1'b1, 1'b1, 64'hA00, 64'hA00, 1'b0);
    idle(1'b0);
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      p   = ($urandom_range(0, 9) < 5);
      idx = IW'($urandom);
      pt  = 1'($urandom_range(0, 1));
      tgt = 64'h100 * 64'($urandom_range(1, 3));
      r   = ($urandom_range(0, 9) < 5);
      st  = ($urandom_range(0, 9) < 2);
      if (mq.size() != 0 && $urandom_range(0, 9) < 7) begin
        rt   = mq[0].pt;
        rtgt = mq[0].tgt;
      end else begin
        rt   = 1'($urandom_range(0, 1));
        rtgt = 64'h100 * 64'($urandom_range(1, 3));
      end
      npc = rt ? rtgt : (64'h4000 + 64'($urandom_range(0, 255)));
      step(p, idx, pt, tgt, r, rt, rtgt, npc, st);
      if (n == 400) do_reset();
    end

    for (int i = 0; i < 4; i++) idle(1'b0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_branch_pred_queue

// File: doc/branch_pred_queue.md
Name: branch_pred_queue

Overview:
- In-order queue between fetch and execute that records each predicted branch's BHT set index, predicted direction and predicted target at fetch.
- At execute resolution it compares the actual outcome with the oldest entry and classifies it as correct or mispredicted.
- Drives the BHT update port (update strobe, taken, exec set index) and a front-end redirect/flush.
- Directly upstream of the BHT update interface; downstream of the fetch-stage predictor.

Parameters:
- DEPTH, 4, number of in-flight branch entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).
- INDEX_WIDTH, 5, BHT set index width.
- ADDR_WIDTH, 64, PC/target width.

Ports:
- clk_i  in  1  clock, rising edge.
- arstn_i  in  1  asynchronous active-low reset.
- stall_fetch_i  in  1  front-end stall; BHT ignores updates while high.
- push_i  in  1  fetch issues a predicted branch.
- push_index_i  in  INDEX_WIDTH  BHT set index used for the prediction.
- push_pred_taken_i  in  1  predicted direction.
- push_pred_target_i  in  ADDR_WIDTH  predicted target; meaningful only if predicted taken.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- count_o  out  PTR_W+1  occupied entries.
- resolve_i  in  1  execute resolves the oldest branch.
- resolve_ready_o  out  1  queue can accept a resolve this cycle.
- resolve_taken_i  in  1  actual direction.
- resolve_target_i  in  ADDR_WIDTH  actual taken target.
- resolve_next_pc_i  in  ADDR_WIDTH  correct next PC (target or fall-through).
- bht_update_o  out  1  BHT update strobe.
- branch_taken_o  out  1  actual direction for the BHT.
- set_index_exec_o  out  INDEX_WIDTH  BHT index to update.
- mispredict_o  out  1  one-cycle redirect/flush pulse.
- redirect_pc_o  out  ADDR_WIDTH  PC to fetch after a mispredict.
- overflow_o  out  1  sticky: push dropped because the queue was full.

Behaviour:
- Reset (arstn_i low, asynchronous):
  - Pointers and count = 0; empty_o = 1; full_o = 0.
  - bht_update_o, branch_taken_o, mispredict_o, overflow_o = 0.
  - set_index_exec_o and redirect_pc_o = 0.
  - resolve_ready_o = 1.
  - Entry storage is not reset.
- Push accepted when push_i & ~full_o & ~stall_fetch_i: write at tail, tail+1 modulo DEPTH.
- push_i while full_o: entry dropped, overflow_o set until reset. A simultaneous resolve does not rescue it; full_o is evaluated from the current count.
- Resolve accepted when resolve_i & resolve_ready_o & ~empty_o: head entry consumed, head+1 modulo DEPTH.
- resolve_i while empty_o: ignored, no outputs generated.
- Mispredict if pred_taken != resolve_taken_i, or if both are taken and pred_target != resolve_target_i.
- Output latency is 1 cycle. Registered on the edge after an accepted resolve:
  - bht_update_o = 1.
  - branch_taken_o = resolve_taken_i.
  - set_index_exec_o = entry index.
  - mispredict_o = mispredict.
  - redirect_pc_o = resolve_next_pc_i (updated only on a mispredict).
- bht_update_o holds while stall_fetch_i is high, keeping the same taken/index values, and clears on the first cycle where stall_fetch_i is low. This guarantees the BHT sees it.
- mispredict_o is always a single-cycle pulse; it is never held.
- resolve_ready_o = ~(bht_update_o & stall_fetch_i). While a held update is pending, no new resolve is accepted.
- Mispredict flush on the resolve edge:
  - head, tail and count reset to 0; all younger entries are discarded.
  - A push in the same cycle is discarded.
- Simultaneous push and correct-prediction resolve: both take effect, count unchanged. Allowed at count == DEPTH only for the resolve; the push is dropped per the full rule.
- Pointers wrap modulo DEPTH; count is the sole full/empty arbiter.

Optional Feature:
- Macro: BPQ_STATS_EN.
- When defined, adds two output ports, each 32 bits, cleared by reset, saturating at all-ones:
  - stat_branches_o counts accepted resolves.
  - stat_mispred_o counts mispredicting resolves.
- When not defined, neither port nor its counters exist. Core behaviour is identical either way.

Test Plan:
- Reset, then push index 3, pred taken, target 0x100; resolve taken, target 0x100 -> next cycle bht_update_o=1, branch_taken_o=1, set_index_exec_o=3, mispredict_o=0; empty_o=1.
- Push index 7, pred not-taken; resolve taken, next_pc 0x2000 -> mispredict_o=1 for one cycle, redirect_pc_o=0x2000, branch_taken_o=1.
- Push 4 entries (indices 1,2,3,4); resolve entry 1 as a mispredict -> count_o=0 next cycle; a later resolve_i is ignored.
- Fill to DEPTH=4 then push index 9 -> full_o=1, overflow_o=1 sticky, count_o stays 4. Then resolve all four -> set_index_exec_o sequence is 1,2,3,4 (wrap correct).
- Resolve with stall_fetch_i high for 3 cycles -> bht_update_o held 3 cycles plus clears after the stall drops; resolve_ready_o=0 during the stall; a second resolve is accepted only afterwards.
- Push and resolve in the same cycle at count 2 with a correct prediction -> count_o stays 2; assert arstn_i mid-stream -> all outputs 0 asynchronously, empty_o=1.
